// File: rtl/diff_ddr_tx_pkg.sv
// diff_ddr_tx_pkg: link-state encoding, default line patterns and sizing helpers for the DDR tx scheduler
package diff_ddr_tx_pkg;

    typedef enum logic [1:0] {HOLDOFF, TRAIN, RUN} tx_state_e;

    localparam logic [3:0] TRAIN_PATTERN_DEF = 4'b1010;
    localparam logic [3:0] IDLE_PATTERN_DEF  = 4'b0000;

    function automatic int nibbles(input int word_width);
        return word_width / 4;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/ddr_tx_word_shifter.sv
// ddr_tx_word_shifter: one-word holding register feeding a nibble shifter, LSB nibble first
module ddr_tx_word_shifter
    import diff_ddr_tx_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  load,
    output logic                  hold_valid,
    output logic                  hold_valid_next,
    output logic                  active,
    output logic                  active_next,
    output logic                  boundary,
    output logic [3:0]            nibble_next
);
    localparam int NIBBLES = nibbles(WORD_WIDTH);
    localparam int NCW     = $clog2(NIBBLES);

    logic [WORD_WIDTH-1:0] hold_data;
    logic [WORD_WIDTH-1:0] sh;
    logic [NCW-1:0]        ncnt;

    assign boundary        = active && ncnt == NCW'(NIBBLES - 1);
    assign hold_valid_next = capture || (hold_valid && !load);
    assign active_next     = load || (active && !boundary);
    assign nibble_next     = load ? hold_data[3:0] : sh[7:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            sh         <= '0;
            ncnt       <= '0;
            active     <= 1'b0;
        end else begin
            hold_valid <= hold_valid_next;
            active     <= active_next;
            if (capture)
                hold_data <= in_data;
            if (load) begin
                sh   <= hold_data;
                ncnt <= '0;
            end else if (active && !boundary) begin
                sh   <= sh >> 4;
                ncnt <= ncnt + NCW'(1);
            end
        end
    end

endmodule

// File: rtl/diff_ddr_tx_scheduler.sv
// diff_ddr_tx_scheduler: link bring-up (holdoff, training) then word-to-nibble streaming for the x4 DDR serializer
module diff_ddr_tx_scheduler
    import diff_ddr_tx_pkg::*;
#(
    parameter int         WORD_WIDTH     = 32,
    parameter int         HOLDOFF_CYCLES = 8,
    parameter int         TRAIN_CYCLES   = 64,
    parameter logic [3:0] TRAIN_PATTERN  = TRAIN_PATTERN_DEF,
    parameter logic [3:0] IDLE_PATTERN   = IDLE_PATTERN_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  train_req,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [3:0]            data,
    output logic                  training,
    output logic                  link_up,
    output logic                  underflow
);
    localparam int CW = $clog2(max3(HOLDOFF_CYCLES, TRAIN_CYCLES, nibbles(WORD_WIDTH)));

    tx_state_e   state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic        pending, pending_d;
    logic        go_train, load, capture;
    logic        hold_valid, hold_valid_next, active, active_next, boundary;
    logic [3:0]  nibble_next;
    logic [3:0]  data_d;
    logic        training_d, link_up_d, in_ready_d, underflow_d;

    assign capture = in_valid && in_ready;

    ddr_tx_word_shifter #(.WORD_WIDTH(WORD_WIDTH)) u_shifter (
        .clk            (clk),
        .reset          (reset),
        .capture        (capture),
        .in_data        (in_data),
        .load           (load),
        .hold_valid     (hold_valid),
        .hold_valid_next(hold_valid_next),
        .active         (active),
        .active_next    (active_next),
        .boundary       (boundary),
        .nibble_next    (nibble_next)
    );

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CW'(1);
        pending_d = 1'b0;
        go_train  = 1'b0;
        load      = 1'b0;
        case (state)
            HOLDOFF: if (cnt == CW'(HOLDOFF_CYCLES - 1)) begin
                state_d = TRAIN;
                cnt_d   = '0;
            end
            // a word held across training is loaded on the last training edge so it follows without a gap
            TRAIN: if (cnt == CW'(TRAIN_CYCLES - 1)) begin
                state_d = RUN;
                cnt_d   = '0;
                load    = hold_valid;
            end
            default: begin
                cnt_d     = cnt;
                go_train  = (pending || train_req) && (!active || boundary);
                load      = !go_train && hold_valid && (!active || boundary);
                pending_d = !go_train && (pending || train_req);
                if (go_train) begin
                    state_d = TRAIN;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign training_d  = state_d == TRAIN;
    assign link_up_d   = state_d == RUN;
    assign in_ready_d  = link_up_d && !hold_valid_next;
    assign underflow_d = state == RUN && boundary && !load && !go_train;
    assign data_d      = training_d ? TRAIN_PATTERN : active_next ? nibble_next : IDLE_PATTERN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HOLDOFF;
            cnt       <= '0;
            pending   <= 1'b0;
            data      <= IDLE_PATTERN;
            in_ready  <= 1'b0;
            training  <= 1'b0;
            link_up   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            pending   <= pending_d;
            data      <= data_d;
            in_ready  <= in_ready_d;
            training  <= training_d;
            link_up   <= link_up_d;
            underflow <= underflow_d;
        end
    end

endmodule

// File: tb/tb_diff_ddr_tx_scheduler.sv
// tb_diff_ddr_tx_scheduler: directed bring-up, streaming, retrain and reset vectors for the DDR tx scheduler
module tb_diff_ddr_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset_a, train_req_a, in_valid_a;
    logic [31:0] in_data_a;
    logic        in_ready_a, training_a, link_up_a, underflow_a;
    logic [3:0]  data_a;
    logic        reset_b, train_req_b, in_valid_b;
    logic [7:0]  in_data_b;
    logic        in_ready_b, training_b, link_up_b, underflow_b;
    logic [3:0]  data_b;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    diff_ddr_tx_scheduler dut_a (
        .clk(clk), .reset(reset_a), .train_req(train_req_a), .in_valid(in_valid_a),
        .in_data(in_data_a), .in_ready(in_ready_a), .data(data_a), .training(training_a),
        .link_up(link_up_a), .underflow(underflow_a)
    );

    diff_ddr_tx_scheduler #(.WORD_WIDTH(8), .HOLDOFF_CYCLES(4), .TRAIN_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset_b), .train_req(train_req_b), .in_valid(in_valid_b),
        .in_data(in_data_b), .in_ready(in_ready_b), .data(data_b), .training(training_b),
        .link_up(link_up_b), .underflow(underflow_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reset is released mid-cycle just before this runs
    task automatic bring_up();
        for (int i = 1; i < 8; i++) begin
            tick();
            check("ho_data", data_a, 4'h0);
            check("ho_training", training_a, 0);
        end
        tick();
        check("tr_start", training_a, 1);
        check("tr_data0", data_a, 4'hA);
        for (int i = 1; i < 64; i++) begin
            tick();
            check("tr_data", data_a, 4'hA);
            check("tr_underflow", underflow_a, 0);
        end
        tick();
        check("run_link", link_up_a, 1);
        check("run_ready", in_ready_a, 1);
        check("run_training", training_a, 0);
        check("run_data", data_a, 4'h0);
        check("run_underflow", underflow_a, 0);
    endtask

    // accept 76543210 then hold FEDCBA98; returns with nibble 1 on data
    task automatic start_pair();
        in_valid_a = 1'b1;
        in_data_a  = 32'h76543210;
        tick();
        check("pair_ready_full", in_ready_a, 0);
        check("pair_latency_idle", data_a, 4'h0);
        in_data_a = 32'hFEDCBA98;
        tick();
        check("pair_n0", data_a, 4'h0);
        check("pair_ready_free", in_ready_a, 1);
        tick();
        in_valid_a = 1'b0;
        check("pair_n1", data_a, 4'h1);
        check("pair_ready_held", in_ready_a, 0);
    endtask

    logic [7:0] w6 [3] = '{8'h21, 8'h43, 8'h65};
    int         wi;
    logic       acc;

    initial begin
        reset_a = 1'b1; train_req_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
        reset_b = 1'b1; train_req_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
        tick();
        tick();
        check("rst_data", data_a, 4'h0);
        check("rst_ready", in_ready_a, 0);
        check("rst_training", training_a, 0);
        check("rst_link", link_up_a, 0);
        check("rst_underflow", underflow_a, 0);
        check("rst_b_ready", in_ready_b, 0);
        #3 reset_a = 1'b0;
        bring_up();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_underflow", underflow_a, 0);
            check("idle_data", data_a, 4'h0);
        end

        start_pair();
        for (int k = 2; k < 16; k++) begin
            tick();
            check("t2_nibble", data_a, k);
            check("t2_underflow", underflow_a, 0);
        end
        tick();
        check("t2_idle", data_a, 4'h0);
        check("t2_uf_pulse", underflow_a, 1);
        tick();
        check("t2_uf_once", underflow_a, 0);

        in_valid_a = 1'b1;
        in_data_a  = 32'hA5A5A5A5;
        tick();
        in_valid_a = 1'b0;
        check("t3_ready_full", in_ready_a, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t3_nibble", data_a, (k % 2 == 0) ? 4'h5 : 4'hA);
            check("t3_ready", in_ready_a, 1);
        end
        tick();
        check("t3_idle", data_a, 4'h0);
        check("t3_uf_pulse", underflow_a, 1);
        tick();
        check("t3_uf_once", underflow_a, 0);

        start_pair();
        tick();
        check("t4_n2", data_a, 4'h2);
        tick();
        check("t4_n3", data_a, 4'h3);
        train_req_a = 1'b1;
        tick();
        train_req_a = 1'b0;
        check("t4_n4", data_a, 4'h4);
        check("t4_link_still", link_up_a, 1);
        for (int k = 5; k < 8; k++) begin
            tick();
            check("t4_finish", data_a, k);
        end
        tick();
        check("t4_training", training_a, 1);
        check("t4_tr_data", data_a, 4'hA);
        check("t4_ready_low", in_ready_a, 0);
        check("t4_no_uf", underflow_a, 0);
        for (int i = 1; i < 64; i++) begin
            tick();
            check("t4_tr", training_a, 1);
            check("t4_tr_uf", underflow_a, 0);
        end
        tick();
        check("t4_held_n0", data_a, 4'h8);
        check("t4_link", link_up_a, 1);
        check("t4_ready_after", in_ready_a, 1);
        for (int k = 9; k < 16; k++) begin
            tick();
            check("t4_held", data_a, k);
            check("t4_held_uf", underflow_a, 0);
        end
        tick();
        check("t4_end_uf", underflow_a, 1);
        tick();

        in_valid_a = 1'b1;
        in_data_a  = 32'h76543210;
        tick();
        in_valid_a = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t5_nibble", data_a, k);
        end
        #2 reset_a = 1'b1;
        #1;
        check("t5_async_data", data_a, 4'h0);
        check("t5_async_ready", in_ready_a, 0);
        check("t5_async_link", link_up_a, 0);
        tick();
        tick();
        #3 reset_a = 1'b0;
        bring_up();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_dropped", data_a, 4'h0);
            check("t5_uf", underflow_a, 0);
        end

        #3 reset_b = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t6_ho", data_b, 4'h0);
            check("t6_ho_tr", training_b, 0);
        end
        tick();
        check("t6_tr", training_b, 1);
        check("t6_tr_data", data_b, 4'hA);
        tick();
        check("t6_link", link_up_b, 1);
        check("t6_ready", in_ready_b, 1);
        check("t6_run_data", data_b, 4'h0);
        wi = 0;
        in_valid_b = 1'b1;
        in_data_b  = w6[0];
        for (int c = 1; c <= 8; c++) begin
            acc = in_ready_b && in_valid_b;
            tick();
            if (acc) wi++;
            in_valid_b = wi < 3;
            in_data_b  = (wi < 3) ? w6[wi] : 8'h00;
            if (c >= 2 && c <= 7) begin
                check("t6_nibble", data_b, c - 1);
                check("t6_uf", underflow_b, 0);
            end else if (c == 8) begin
                check("t6_idle", data_b, 4'h0);
                check("t6_uf_pulse", underflow_b, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
